// File: rtl/rtc_pkg.sv
// Shared field widths, reset constants and month-length rule for the RTC.
package rtc_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int DAY_W  = 5;
  localparam int MON_W  = 4;
  localparam int YEAR_W = 7;

  localparam logic [SEC_W-1:0]  RST_SEC  = '0;
  localparam logic [MIN_W-1:0]  RST_MIN  = '0;
  localparam logic [HOUR_W-1:0] RST_HOUR = '0;
  localparam logic [DAY_W-1:0]  RST_DAY  = DAY_W'(1);
  localparam logic [MON_W-1:0]  RST_MON  = MON_W'(1);
  localparam logic [YEAR_W-1:0] RST_YEAR = '0;

  // Every multiple of 4 in 2000..2099 is a leap year, including 2000.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0]  month,
                                                     input logic [YEAR_W-1:0] year);
    logic [DAY_W-1:0] d;
    case (month)
      MON_W'(2):                                   d = ((year & YEAR_W'(3)) == '0) ? DAY_W'(29) : DAY_W'(28);
      MON_W'(4), MON_W'(6), MON_W'(9), MON_W'(11): d = DAY_W'(30);
      default:                                     d = DAY_W'(31);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rtc_calendar_tick_gen.sv
// Prescaler: counts 0..CLK_HZ-1 while run is high, flags the terminal count.
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clr_i,
  output logic tc_o
);
  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Terminal count only matters while running, so a frozen counter never ticks.
  assign tc_o = run_i && (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o) cnt_d = '0;
    else if (run_i)    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rtc_calendar.sv
// Calendar counters (s/m/h/day/month/year) with single-cycle carry chain and
// a validated parallel load port.
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load,
  input  logic [SEC_W-1:0]  ld_second,
  input  logic [MIN_W-1:0]  ld_minute,
  input  logic [HOUR_W-1:0] ld_hour,
  input  logic [DAY_W-1:0]  ld_day,
  input  logic [MON_W-1:0]  ld_month,
  input  logic [YEAR_W-1:0] ld_year,
  output logic [SEC_W-1:0]  second,
  output logic [MIN_W-1:0]  minute,
  output logic [HOUR_W-1:0] hour,
  output logic [DAY_W-1:0]  day,
  output logic [MON_W-1:0]  month,
  output logic [YEAR_W-1:0] year,
  output logic              tick_1hz,
  output logic              load_err
);
  logic [SEC_W-1:0]  sec_q,  sec_d;
  logic [MIN_W-1:0]  min_q,  min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic [DAY_W-1:0]  day_q,  day_d;
  logic [MON_W-1:0]  mon_q,  mon_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic              tick_q, tick_d;
  logic              err_q,  err_d;
  logic              tc, ld_valid, load_ok;

  assign ld_valid = (ld_second < SEC_W'(60)) && (ld_minute < MIN_W'(60)) &&
                    (ld_hour < HOUR_W'(24)) &&
                    (ld_month >= MON_W'(1)) && (ld_month <= MON_W'(12)) &&
                    (ld_year < YEAR_W'(100)) && (ld_day >= DAY_W'(1)) &&
                    (ld_day <= days_in_month(ld_month, ld_year));
  assign load_ok = load && ld_valid;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run_i (run),
    .clr_i (load_ok),
    .tc_o  (tc)
  );

  // An accepted load overrides the tick; a rejected one leaves the tick alone.
  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    day_d  = day_q;
    mon_d  = mon_q;
    year_d = year_q;
    tick_d = tc && !load_ok;
    err_d  = load && !ld_valid;
    if (load_ok) begin
      sec_d  = ld_second;
      min_d  = ld_minute;
      hour_d = ld_hour;
      day_d  = ld_day;
      mon_d  = ld_month;
      year_d = ld_year;
    end else if (tc) begin
      if (sec_q != SEC_W'(59)) sec_d = sec_q + 1'b1;
      else begin
        sec_d = '0;
        if (min_q != MIN_W'(59)) min_d = min_q + 1'b1;
        else begin
          min_d = '0;
          if (hour_q != HOUR_W'(23)) hour_d = hour_q + 1'b1;
          else begin
            hour_d = '0;
            if (day_q != days_in_month(mon_q, year_q)) day_d = day_q + 1'b1;
            else begin
              day_d = DAY_W'(1);
              if (mon_q != MON_W'(12)) mon_d = mon_q + 1'b1;
              else begin
                mon_d  = MON_W'(1);
                year_d = (year_q == YEAR_W'(99)) ? '0 : year_q + 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sec_q  <= RST_SEC;
      min_q  <= RST_MIN;
      hour_q <= RST_HOUR;
      day_q  <= RST_DAY;
      mon_q  <= RST_MON;
      year_q <= RST_YEAR;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      day_q  <= day_d;
      mon_q  <= mon_d;
      year_q <= year_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign second   = sec_q;
  assign minute   = min_q;
  assign hour     = hour_q;
  assign day      = day_q;
  assign month    = mon_q;
  assign year     = year_q;
  assign tick_1hz = tick_q;
  assign load_err = err_q;
endmodule
